// File: rtl/sprite_move_if.sv
// Request/response and map-RAM port-b signals shared by the sprite move writer
// and the movement controllers that drive it.
interface sprite_move_if;
  logic         req;
  logic [5:0]   src_x;
  logic [4:0]   src_y;
  logic [5:0]   dst_x;
  logic [4:0]   dst_y;
  logic [3:0]   sprite_code;
  logic [3:0]   restore_code;
  logic         busy;
  logic         done;
  logic         err;
  logic [3:0]   dest_code;
  logic [4:0]   wraddr;
  logic [159:0] wrdata;
  logic         wren;
  logic [159:0] redata;

  modport slave (
    input  req, src_x, src_y, dst_x, dst_y, sprite_code, restore_code, redata,
    output busy, done, err, dest_code, wraddr, wrdata, wren
  );

  modport master (
    output req, src_x, src_y, dst_x, dst_y, sprite_code, restore_code, redata,
    input  busy, done, err, dest_code, wraddr, wrdata, wren
  );
endinterface

// File: rtl/sprite_move_writer.sv
// Read-modify-write engine that moves one sprite tile between two map cells and
// reports the tile that was under the destination before the overwrite.
module sprite_move_writer #(
  parameter int RD_LAT = 1,
  parameter int MAX_X  = 39,
  parameter int MAX_Y  = 29
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  sprite_move_if.slave mv
);

  typedef enum logic [2:0] {IDLE, RD_SRC, WR_SRC, RD_DST, WR_DST, DONE} state_t;

  state_t         state_q;
  logic [7:0]     cnt_q;
  logic [5:0]     sx_q, dx_q;
  logic [4:0]     sy_q, dy_q;
  logic [3:0]     spr_q, restore_q;
  logic           busy_q, done_q, err_q, wren_q;
  logic [4:0]     wraddr_q;
  logic [159:0]   wrdata_q;
  logic [3:0]     dest_q;

  logic           same_row_d, same_cell_d, req_bad_d, rd_last_d;
  logic [159:0]   src_row_d, both_row_d, dst_row_d;
  logic [3:0]     dst_nib_d;

  function automatic logic [159:0] put_nib(input logic [159:0] row,
                                           input logic [5:0] col,
                                           input logic [3:0] code);
    logic [159:0] r;
    r = row;
    r[156 - 4*int'(col) +: 4] = code;
    return r;
  endfunction

  function automatic logic [3:0] get_nib(input logic [159:0] row,
                                         input logic [5:0] col);
    return row[156 - 4*int'(col) +: 4];
  endfunction

  always_comb begin
    same_row_d  = (sy_q == dy_q);
    same_cell_d = same_row_d && (sx_q == dx_q);
    req_bad_d   = (int'(mv.src_x) > MAX_X) || (int'(mv.dst_x) > MAX_X) ||
                  (int'(mv.src_y) > MAX_Y) || (int'(mv.dst_y) > MAX_Y);
    rd_last_d   = (cnt_q == 8'(RD_LAT));
    src_row_d   = put_nib(mv.redata, sx_q, restore_q);
    both_row_d  = put_nib(src_row_d, dx_q, spr_q);
    dst_row_d   = put_nib(mv.redata, dx_q, spr_q);
    dst_nib_d   = get_nib(mv.redata, dx_q);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wren_q   <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= '0;
      dest_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      wren_q <= 1'b0;
      case (state_q)
        IDLE: if (mv.req) begin
          sx_q      <= mv.src_x;
          sy_q      <= mv.src_y;
          dx_q      <= mv.dst_x;
          dy_q      <= mv.dst_y;
          spr_q     <= mv.sprite_code;
          restore_q <= mv.restore_code;
          busy_q    <= 1'b1;
          cnt_q     <= '0;
          if (req_bad_d) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            state_q  <= RD_SRC;
            wraddr_q <= mv.src_y;
          end
        end
        // Source row read; same-row moves resolve everything from this one read
        RD_SRC: if (rd_last_d) begin
          cnt_q <= '0;
          if (same_cell_d) begin
            dest_q  <= dst_nib_d;
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (same_row_d) begin
            dest_q   <= dst_nib_d;
            wrdata_q <= both_row_d;
            wren_q   <= 1'b1;
            state_q  <= WR_SRC;
          end else begin
            wrdata_q <= src_row_d;
            wren_q   <= 1'b1;
            state_q  <= WR_SRC;
          end
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
        WR_SRC: if (same_row_d) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end else begin
          state_q  <= RD_DST;
          wraddr_q <= dy_q;
        end
        RD_DST: if (rd_last_d) begin
          cnt_q    <= '0;
          dest_q   <= dst_nib_d;
          wrdata_q <= dst_row_d;
          wren_q   <= 1'b1;
          state_q  <= WR_DST;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
        WR_DST: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mv.busy      = busy_q;
  assign mv.done      = done_q;
  assign mv.err       = err_q;
  assign mv.dest_code = dest_q;
  assign mv.wraddr    = wraddr_q;
  assign mv.wrdata    = wrdata_q;
  assign mv.wren      = wren_q;

endmodule

// File: tb/tb_sprite_move_writer.sv
// Bench for sprite_move_writer: behavioural map RAM, table of move requests and
// hand-written sequences for reset and DONE-cycle request handling.
module tb_sprite_move_writer;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sprite_move_if mif ();

  sprite_move_writer #(.RD_LAT(RD_LAT), .MAX_X(39), .MAX_Y(29)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .mv       (mif)
  );

  logic [159:0] mem [0:31];
  logic         poke_en;
  logic [4:0]   poke_a;
  logic [159:0] poke_d;

  always @(posedge clk) begin
    if (poke_en) mem[poke_a] <= poke_d;
    else if (mif.wren) mem[mif.wraddr] <= mif.wrdata;
    mif.redata <= mem[mif.wraddr];
  end

  typedef struct {
    logic [5:0] sx; logic [4:0] sy; logic [5:0] dx; logic [4:0] dy;
    logic [3:0] spr; logic [3:0] rsc; logic [3:0] pre_s; logic [3:0] pre_d;
    bit poke; int lat; bit err; logic [3:0] dest;
  } vec_t;

  typedef struct { logic [4:0] addr; logic [159:0] data; int cyc; } wr_t;

  wr_t  exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [159:0] with_nib(input logic [159:0] row, input logic [5:0] col,
                                            input logic [3:0] code);
    logic [159:0] r;
    r = row;
    r[(39 - int'(col)) * 4 +: 4] = code;
    return r;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [4:0] a, input logic [159:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic preload(input vec_t v);
    if (v.poke) begin
      poke(v.sy, with_nib(mem[v.sy], v.sx, v.pre_s));
      poke(v.dy, with_nib(mem[v.dy], v.dx, v.pre_d));
    end
  endtask

  task automatic drive(input vec_t v);
    mif.req = 1'b1;
    mif.src_x = v.sx; mif.src_y = v.sy; mif.dst_x = v.dx; mif.dst_y = v.dy;
    mif.sprite_code = v.spr; mif.restore_code = v.rsc;
  endtask

  task automatic push_exp(input vec_t v);
    wr_t w;
    if (!v.err && !(v.sy == v.dy && v.sx == v.dx)) begin
      if (v.sy == v.dy) begin
        w.addr = v.sy;
        w.data = with_nib(with_nib(mem[v.sy], v.sx, v.rsc), v.dx, v.spr);
        w.cyc  = RD_LAT + 2;
        exp_q.push_back(w);
      end else begin
        w.addr = v.sy; w.data = with_nib(mem[v.sy], v.sx, v.rsc); w.cyc = RD_LAT + 2;
        exp_q.push_back(w);
        w.addr = v.dy; w.data = with_nib(mem[v.dy], v.dx, v.spr); w.cyc = 2 * RD_LAT + 4;
        exp_q.push_back(w);
      end
    end
  endtask

  // Request accepted on the next edge; negedge n of this loop is cycle n.
  task automatic watch(input vec_t v);
    bit  got;
    wr_t w;
    got = 1'b0;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if (n == 1) begin
        mif.req = 1'b0;
        mif.src_x = 6'($urandom); mif.dst_x = 6'($urandom);
        mif.src_y = 5'($urandom); mif.dst_y = 5'($urandom);
        mif.sprite_code = 4'($urandom); mif.restore_code = 4'($urandom);
      end
      if (mif.wren) begin
        if (exp_q.size() == 0) check("unexpected_wren_cycle", 160'(n), 160'(0));
        else begin
          w = exp_q.pop_front();
          check("wr_addr", 160'(mif.wraddr), 160'(w.addr));
          check("wr_data", mif.wrdata, w.data);
          check("wr_cycle", 160'(n), 160'(w.cyc));
        end
      end
      check("busy_active", 160'(mif.busy), 160'(1));
      if (mif.done) begin
        got = 1'b1;
        check("done_cycle", 160'(n), 160'(v.lat));
        check("err", 160'(mif.err), 160'(v.err));
        check("dest_code", 160'(mif.dest_code), 160'(v.dest));
      end
    end
    if (!got) check("done_timeout", 160'(0), 160'(1));
    check("pending_writes", 160'(exp_q.size()), 160'(0));
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    preload(v);
    @(negedge clk);
    check("idle_busy", 160'(mif.busy), 160'(0));
    check("done_one_cycle", 160'(mif.done), 160'(0));
    push_exp(v);
    drive(v);
    watch(v);
  endtask

  vec_t tbl [8];
  vec_t va, vb, vr;

  initial begin
    int wrs;
    logic [159:0] orig_d, exp_src;

    //            sx  sy  dx  dy  spr   rsc   pre_s pre_d poke lat err dest
    tbl[0] = '{6'd3,  5'd5,  6'd3,  5'd6,  4'h8, 4'h0, 4'h8, 4'h2, 1, 7, 0, 4'h2};
    tbl[1] = '{6'd0,  5'd10, 6'd39, 5'd10, 4'hA, 4'h2, 4'hA, 4'h5, 1, 4, 0, 4'h5};
    tbl[2] = '{6'd12, 5'd12, 6'd12, 5'd12, 4'h1, 4'h0, 4'h1, 4'h1, 1, 3, 0, 4'h1};
    tbl[3] = '{6'd1,  5'd0,  6'd40, 5'd0,  4'h9, 4'h9, 4'h0, 4'h0, 0, 1, 1, 4'h1};
    tbl[4] = '{6'd5,  5'd30, 6'd2,  5'd2,  4'h9, 4'h9, 4'h0, 4'h0, 0, 1, 1, 4'h1};
    tbl[5] = '{6'd39, 5'd29, 6'd0,  5'd0,  4'h3, 4'h7, 4'h3, 4'hC, 1, 7, 0, 4'hC};
    tbl[6] = '{6'd20, 5'd15, 6'd21, 5'd15, 4'h6, 4'h0, 4'h6, 4'hF, 1, 4, 0, 4'hF};
    tbl[7] = '{6'd21, 5'd15, 6'd20, 5'd15, 4'h6, 4'hF, 4'h0, 4'h0, 0, 4, 0, 4'h0};

    rst = 1'b1; poke_en = 1'b0; poke_a = '0; poke_d = '0;
    mif.req = 1'b0; mif.src_x = '0; mif.src_y = '0; mif.dst_x = '0; mif.dst_y = '0;
    mif.sprite_code = '0; mif.restore_code = '0;
    for (int r = 0; r < 32; r++)
      poke(5'(r), {$urandom, $urandom, $urandom, $urandom, $urandom});

    // Reset held with a request pending; accepted on the first edge after release
    preload(tbl[0]);
    @(negedge clk);
    drive(tbl[0]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_busy", 160'(mif.busy), 160'(0));
      check("rst_wren", 160'(mif.wren), 160'(0));
      check("rst_dest", 160'(mif.dest_code), 160'(0));
      check("rst_done", 160'(mif.done), 160'(0));
    end
    rst = 1'b0;
    push_exp(tbl[0]);
    watch(tbl[0]);

    for (int i = 1; i < 8; i++) run_vec(tbl[i]);

    // Request presented during DONE is ignored, then taken in the next IDLE cycle
    va = '{6'd2, 5'd8, 6'd2, 5'd8, 4'h4, 4'h0, 4'h4, 4'h4, 1, 3, 0, 4'h4};
    vb = '{6'd4, 5'd8, 6'd5, 5'd8, 4'hB, 4'h0, 4'hB, 4'hD, 1, 4, 0, 4'hD};
    preload(va);
    preload(vb);
    @(negedge clk);
    push_exp(va);
    drive(va);
    watch(va);
    drive(vb);
    @(negedge clk);
    check("req_in_done_ignored", 160'(mif.busy), 160'(0));
    push_exp(vb);
    watch(vb);

    // Reset in cycle 4 of a different-row move
    vr = '{6'd10, 5'd3, 6'd11, 5'd4, 4'h8, 4'h0, 4'h8, 4'h2, 1, 7, 0, 4'h2};
    preload(vr);
    @(negedge clk);
    exp_src = with_nib(mem[3], 6'd10, 4'h0);
    orig_d  = mem[4];
    drive(vr);
    wrs = 0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) mif.req = 1'b0;
      if (mif.wren) begin
        wrs++;
        check("midrst_wr_addr", 160'(mif.wraddr), 160'(3));
        check("midrst_wr_data", mif.wrdata, exp_src);
      end
      check("midrst_no_done", 160'(mif.done), 160'(0));
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 160'(mif.busy), 160'(0));
    check("midrst_done", 160'(mif.done), 160'(0));
    check("midrst_wren", 160'(mif.wren), 160'(0));
    check("midrst_dest", 160'(mif.dest_code), 160'(0));
    check("midrst_write_count", 160'(wrs), 160'(1));
    check("midrst_src_row", mem[3], exp_src);
    check("midrst_dst_row", mem[4], orig_d);
    rst = 1'b0;
    run_vec('{6'd1, 5'd20, 6'd1, 5'd21, 4'h5, 4'h0, 4'h5, 4'h3, 1, 7, 0, 4'h3});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
